deca_input_conditioner: RTL



---
 rtl/deca_input_conditioner.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/deca_input_conditioner.sv
// Deca board input front-end: pin synchronisers, debouncers, press/release strobes,
// long-press detect and stretched SoC reset. Define DECA_LONG_PRESS_RESET_EN for long-press soft reset.
module deca_input_conditioner #(
  parameter int                    NUM_INPUTS         = 3,
  parameter logic [NUM_INPUTS-1:0] ACTIVE_LOW_MASK    = 3'b001,
  parameter int                    DEBOUNCE_CYCLES    = 1000000,
  parameter int                    LONG_PRESS_CYCLES  = 150000000,
  parameter int                    RST_STRETCH_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_INPUTS-1:0] i_raw,
  output logic [NUM_INPUTS-1:0] o_level,
  output logic [NUM_INPUTS-1:0] o_rise,
  output logic [NUM_INPUTS-1:0] o_fall,
  output logic                  o_long_press,
  output logic                  o_soc_rst
);

  // state    | meaning
  // S_HOLD   | power-on / pin reset, o_soc_rst high while the stretch counter runs
  // S_RUN    | core running
  // S_SOFT   | long-press soft reset, o_soc_rst high while the stretch counter runs
  // S_WAIT_REL | core running, soft reset re-armed only once key1 is released
`ifdef DECA_LONG_PRESS_RESET_EN
  typedef enum logic [1:0] {S_HOLD, S_RUN, S_SOFT, S_WAIT_REL} state_t;
`else
  typedef enum logic [1:0] {S_HOLD, S_RUN} state_t;
`endif

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int LP_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int ST_W = $clog2(RST_STRETCH_CYCLES + 1);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [LP_W-1:0] LP_SAT  = LP_W'(LONG_PRESS_CYCLES);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(RST_STRETCH_CYCLES - 1);

  logic [NUM_INPUTS-1:0] sync1_q, sync1_d;
  logic [NUM_INPUTS-1:0] sync2_q, sync2_d;
  logic [NUM_INPUTS-1:0] level_q, level_d;
  logic [NUM_INPUTS-1:0] rise_q, rise_d;
  logic [NUM_INPUTS-1:0] fall_q, fall_d;
  logic [DB_W-1:0]       db_cnt_q [NUM_INPUTS];
  logic [DB_W-1:0]       db_cnt_d [NUM_INPUTS];
  logic [LP_W-1:0]       lp_cnt_q, lp_cnt_d;
  logic                  long_press_q, long_press_d;
  state_t                state_q, state_d;
  logic [ST_W-1:0]       st_cnt_q, st_cnt_d;
  logic                  soc_rst_q, soc_rst_d;

  always_comb begin
    sync1_d = i_raw ^ ACTIVE_LOW_MASK;
    sync2_d = sync1_q;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i] = sync2_q[i];
          rise_d[i]  = sync2_q[i];
          fall_d[i]  = ~sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Counter saturates one past the trigger value so the strobe cannot repeat until release.
  always_comb begin
    lp_cnt_d     = '0;
    long_press_d = 1'b0;
    if (level_q[0]) begin
      lp_cnt_d = lp_cnt_q;
      if (lp_cnt_q != LP_SAT) begin
        lp_cnt_d = lp_cnt_q + LP_W'(1);
      end
      long_press_d = (lp_cnt_q == LP_LAST);
    end
  end

  always_comb begin
    state_d  = state_q;
    st_cnt_d = '0;
    case (state_q)
      S_HOLD: begin
        if (st_cnt_q == ST_LAST) begin
          state_d = S_RUN;
        end else begin
          st_cnt_d = st_cnt_q + ST_W'(1);
        end
      end
      S_RUN: begin
`ifdef DECA_LONG_PRESS_RESET_EN
        if (long_press_q) begin
          state_d = S_SOFT;
        end
`endif
      end
`ifdef DECA_LONG_PRESS_RESET_EN
      S_SOFT: begin
        if (st_cnt_q == ST_LAST) begin
          state_d = S_WAIT_REL;
        end else begin
          st_cnt_d = st_cnt_q + ST_W'(1);
        end
      end
      S_WAIT_REL: begin
        if (!level_q[0]) begin
          state_d = S_RUN;
        end
      end
`endif
      default: state_d = S_HOLD;
    endcase
`ifdef DECA_LONG_PRESS_RESET_EN
    soc_rst_d = (state_d == S_HOLD) || (state_d == S_SOFT);
`else
    soc_rst_d = (state_d == S_HOLD);
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      rise_q       <= '0;
      fall_q       <= '0;
      db_cnt_q     <= '{default: '0};
      lp_cnt_q     <= '0;
      long_press_q <= 1'b0;
      state_q      <= S_HOLD;
      st_cnt_q     <= '0;
      soc_rst_q    <= 1'b1;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      db_cnt_q     <= db_cnt_d;
      lp_cnt_q     <= lp_cnt_d;
      long_press_q <= long_press_d;
      state_q      <= state_d;
      st_cnt_q     <= st_cnt_d;
      soc_rst_q    <= soc_rst_d;
    end
  end

  assign o_level      = level_q;
  assign o_rise       = rise_q;
  assign o_fall       = fall_q;
  assign o_long_press = long_press_q;
  assign o_soc_rst    = soc_rst_q;

endmodule
